halt_ctrl: RTL

End-of-program controller inside `mips`: it watches the fetch-stage PC and detects program termination. On termination it freezes fetch, lets the instructions already in flight drain through the remaining pipeline stages, then raises a sticky `halt_done` flag together with a cause code and a cycle count. The bench polls `halt_done` to stop simulation instead of probing internal PC state.

---
 rtl/halt_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/halt_ctrl.sv
// End-of-program detector: freezes fetch on a terminating PC, drains the pipeline, then flags halt_done.
// Optional macro HALT_LOOP_DETECT_EN compiles in self-loop detection (cause 11).
module halt_ctrl #(
    parameter logic [31:0] IM_BASE      = 32'h0000_3000,
    parameter logic [31:0] IM_END       = 32'h0000_4000,
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter int unsigned LOOP_LIMIT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        stall,
    output logic        freeze,
    output logic        halt_done,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycles
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [1:0] CAUSE_END   = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_LOOP  = 2'b11;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    if (LOOP_LIMIT == 0) begin : g_bad_loop_limit
        $error("halt_ctrl: LOOP_LIMIT must be at least 1");
    end

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_freeze, w_freeze_nxt;
    logic               r_done, w_done_nxt;
    logic [1:0]         r_cause, w_cause_nxt;
    logic [31:0]        r_cycles, w_cycles_nxt;
    logic               w_end, w_range, w_loop, w_trig;
    logic [1:0]         w_cause;

    // 33-bit sum so a PC near the top of the address space cannot wrap past IM_END
    assign w_end   = ({1'b0, pc} + 33'd4) >= {1'b0, IM_END};
    assign w_range = (pc < IM_BASE) || (pc[1:0] != 2'b00);

`ifdef HALT_LOOP_DETECT_EN
    localparam int unsigned RUN_W = (LOOP_LIMIT > 1) ? $clog2(LOOP_LIMIT + 1) : 1;

    logic [31:0]      r_prev_pc;
    logic [RUN_W-1:0] r_run, w_run_nxt;

    // Length of the current run of identical valid fetches, saturating at LOOP_LIMIT
    always_comb begin
        w_run_nxt = r_run;
        if (pc_valid) begin
            if ((r_run != '0) && (pc == r_prev_pc)) begin
                if (r_run < RUN_W'(LOOP_LIMIT)) begin
                    w_run_nxt = r_run + RUN_W'(1);
                end
            end else begin
                w_run_nxt = RUN_W'(1);
            end
        end
    end

    assign w_loop = pc_valid && (w_run_nxt >= RUN_W'(LOOP_LIMIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_pc <= '0;
            r_run     <= '0;
        end else if ((r_state == S_RUN) && pc_valid) begin
            r_prev_pc <= pc;
            r_run     <= w_run_nxt;
        end
    end
`else
    assign w_loop = 1'b0;
`endif

    assign w_trig  = pc_valid && (w_end || w_range || w_loop);
    assign w_cause = w_end ? CAUSE_END : (w_range ? CAUSE_RANGE : CAUSE_LOOP);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_freeze_nxt = r_freeze;
        w_done_nxt   = r_done;
        w_cause_nxt  = r_cause;
        w_cycles_nxt = r_cycles;

        if ((r_state != S_DONE) && (r_cycles != 32'hFFFF_FFFF)) begin
            w_cycles_nxt = r_cycles + 32'd1;
        end

        case (r_state)
            S_RUN: begin
                if (w_trig) begin
                    w_state_nxt  = S_DRAIN;
                    w_cause_nxt  = w_cause;
                    w_freeze_nxt = 1'b1;
                    w_cnt_nxt    = CNT_W'(DRAIN_CYCLES);
                end
            end
            S_DRAIN: begin
                // A stalled cycle retires nothing, so it neither counts down nor finishes the drain
                if (!stall) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_freeze_nxt = 1'b1;
                w_done_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_freeze <= 1'b0;
            r_done   <= 1'b0;
            r_cause  <= 2'b00;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_freeze <= w_freeze_nxt;
            r_done   <= w_done_nxt;
            r_cause  <= w_cause_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    assign freeze     = r_freeze;
    assign halt_done  = r_done;
    assign halt_cause = r_cause;
    assign cycles     = r_cycles;

endmodule
